clk_enable_scheduler: RTL and testbench
=======================================

Name: clk_enable_scheduler

Overview:
- Programmable clock sequencer for the design's single free-running `clk`.
- Generates a divided clock `div_clk` and a one-cycle `tick` enable for downstream logic, with a configurable half-period and burst length.
- A config handshake loads the settings, and start/stop control the sequence.
- Downstream blocks use `tick` as a clock enable instead of generating their own delayed clocks.

Parameters:
- CNT_W, 16, width of the half-period, burst count and period counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  high only in IDLE; config is accepted on `cfg_valid && cfg_ready`.
- cfg_half  input  CNT_W  half-period in clk cycles; 0 is treated as 1.
- cfg_count  input  CNT_W  number of div_clk periods to run; 0 means free-run.
- start  input  1  start request, sampled in IDLE.
- stop  input  1  stop request.
- div_clk  output  1  registered divided clock.
- tick  output  1  one-cycle pulse in the first cycle of each div_clk high phase.
- busy  output  1  high in RUN and STOPPING.
- done  output  1  one-cycle pulse when a counted burst completes.
- periods  output  CNT_W  completed div_clk periods since the last start.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state=IDLE; div_clk=0, tick=0, busy=0, done=0, periods=0, internal cnt=0.
  - Latched half=1, latched count=0, loaded=0; cfg_ready=1 once state is IDLE.
- States: IDLE, RUN, STOPPING. cfg_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE:
  - A config handshake latches half (0 is mapped to 1) and count, and sets loaded=1.
  - `start && loaded && !stop` at edge E0: cnt<=0, div_clk<=0, periods<=0, state<=RUN.
  - start without loaded is ignored.
  - start and stop together: stop wins and the block stays in IDLE.
  - Config and start in the same cycle: the config is latched and start is ignored that cycle.
- RUN, each edge:
  - If cnt==half-1: cnt<=0 and div_clk toggles. Otherwise cnt++.
  - Resulting timing: div_clk rises at E0+half, falls at E0+2*half, and so on; period = 2*half cycles.
- tick: registered; high exactly in the cycle after each 0→1 toggle (coincident with div_clk's first high cycle), for 1 cycle.
- periods:
  - Increments on each 1→0 toggle.
  - In free-run it wraps from all-ones to 0.
- Counted mode (count≠0):
  - On the 1→0 toggle where periods+1==count: periods<=count, done<=1 for one cycle, state<=IDLE.
  - div_clk stays 0.
- stop in RUN:
  - If div_clk==0: state<=IDLE at the next edge. div_clk stays 0, no done.
  - If div_clk==1: state<=STOPPING.
- STOPPING:
  - Continues counting until the 1→0 toggle, then IDLE, so no truncated high phase.
  - No done pulse. If that toggle also completes the count, done pulses.
- start in RUN or STOPPING is ignored. cfg_valid while busy is not accepted (cfg_ready=0).
- half=1: div_clk toggles every cycle and tick fires every 2 cycles.
- After a run, loaded stays 1, so start reruns with the same config.

Optional Feature:
- Macro: CLK_SCHED_PAUSE_EN.
- When defined, adds input `pause` (1 bit). While pause=1 in RUN or STOPPING:
  - cnt, div_clk and periods hold; tick=0.
  - stop is still registered and acts once pause drops.
  - Counting resumes exactly where it left off, with no phase loss.
- When not defined: no pause port and no hold logic.

Test Plan:
- Reset mid-run: rst pulsed in RUN with div_clk=1 → div_clk, tick, busy, periods, done all 0 immediately; cfg_ready=1 after release.
- Counted burst: cfg_half=3, cfg_count=4, then start → div_clk rises at E0+3, period 6 cycles, 4 ticks, done pulse at E0+24, periods=4, busy low afterwards.
- Free-run with zero half: cfg_half=0, cfg_count=0 → div_clk toggles every cycle and tick every 2 cycles. After 2^CNT_W periods (CNT_W=4 build), periods wraps 15→0.
- Stop during high phase: half=5, stop asserted 2 cycles into the high phase → STOPPING, falls at the normal edge, then IDLE, no done. Stop during low phase → IDLE next edge.
- Handshake and collisions:
  - cfg_valid while busy → not accepted.
  - start before any config → ignored.
  - start and stop together in IDLE → stays IDLE.
- CLK_SCHED_PAUSE_EN: half=4, pause held 10 cycles mid-high-phase → high phase lasts 14 cycles total, periods unchanged during the pause.

Source files
------------

// File: rtl/clk_enable_scheduler.sv
// Purpose : programmable divided-clock sequencer producing div_clk and a one-cycle tick enable.
// Latency : div_clk rises half cycles after the start edge; all outputs registered (tick/done 1 cycle pulses).
// Backpress: config accepted only while idle (cfg_ready); start/cfg_valid are ignored while busy.
//
// Ports:
//   clk, rst               - system clock, asynchronous active-high reset
//   cfg_valid/cfg_ready    - config handshake carrying cfg_half (0 -> 1) and cfg_count (0 = free-run)
//   start, stop            - sequence control
//   div_clk, tick          - divided clock and its first-high-cycle enable pulse
//   busy, done, periods    - status: running, counted burst complete, completed periods since start
// Optional: define CLK_SCHED_PAUSE_EN to add a 'pause' input that freezes a running sequence.
module clk_enable_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
`ifdef CLK_SCHED_PAUSE_EN
    input  logic             pause,
`endif
    output logic             div_clk,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] periods
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] periods_q, periods_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             loaded_q, loaded_d;

    logic             cfg_fire;
    logic             start_fire;
    logic             hold;
    logic             stop_req;
    logic             advance;
    logic             wrap;
    logic             rise;
    logic             fall;
    logic             burst_end;
    logic [CNT_W-1:0] periods_inc;

`ifdef CLK_SCHED_PAUSE_EN
    // A stop seen while paused is remembered and acted on once pause drops.
    logic stop_pend_q, stop_pend_d;
    assign hold        = pause && (state_q != IDLE);
    assign stop_req    = stop || stop_pend_q;
    assign stop_pend_d = (state_q != IDLE) && hold && (stop || stop_pend_q);
`else
    assign hold     = 1'b0;
    assign stop_req = stop;
`endif

    assign cfg_fire    = cfg_valid && (state_q == IDLE);
    // Config wins over start in the same cycle; stop wins over start.
    assign start_fire  = (state_q == IDLE) && !cfg_fire && start && loaded_q && !stop;
    // A stop in the low phase ends the run without letting div_clk rise again.
    assign advance     = (state_q != IDLE) && !hold &&
                         !((state_q == RUN) && stop_req && !div_clk_q);
    assign wrap        = (cnt_q == (half_q - ONE));
    assign rise        = advance && wrap && !div_clk_q;
    assign fall        = advance && wrap && div_clk_q;
    assign periods_inc = periods_q + ONE;
    assign burst_end   = fall && (count_q != '0) && (periods_inc == count_q);

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_q      <= ONE;
            count_q     <= '0;
            periods_q   <= '0;
            div_clk_q   <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            loaded_q    <= 1'b0;
`ifdef CLK_SCHED_PAUSE_EN
            stop_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            count_q     <= count_d;
            periods_q   <= periods_d;
            div_clk_q   <= div_clk_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            loaded_q    <= loaded_d;
`ifdef CLK_SCHED_PAUSE_EN
            stop_pend_q <= stop_pend_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_fire) state_d = RUN;
            end
            RUN: begin
                // If the stop edge is also the falling edge, the high phase is
                // already complete and there is nothing left to finish.
                if (!hold && stop_req) state_d = (div_clk_q && !fall) ? STOPPING : IDLE;
                else if (burst_end)    state_d = IDLE;
            end
            STOPPING: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        count_d   = count_q;
        periods_d = periods_q;
        div_clk_d = div_clk_q;
        loaded_d  = loaded_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;

        if (cfg_fire) begin
            half_d   = (cfg_half == '0) ? ONE : cfg_half;
            count_d  = cfg_count;
            loaded_d = 1'b1;
        end

        if (start_fire) begin
            cnt_d     = '0;
            div_clk_d = 1'b0;
            periods_d = '0;
        end else if (advance) begin
            if (wrap) begin
                cnt_d     = '0;
                div_clk_d = !div_clk_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
            tick_d = rise;
            done_d = burst_end;
            if (fall) periods_d = burst_end ? count_q : periods_inc;
        end
    end

    // Outputs
    always_comb begin
        cfg_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        div_clk   = div_clk_q;
        tick      = tick_q;
        done      = done_q;
        periods   = periods_q;
    end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Purpose : directed self-checking bench for clk_enable_scheduler (CNT_W=4 build).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpress: n/a (bench only).
module tb_clk_enable_scheduler;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_half;
    logic [W-1:0] cfg_count;
    logic         start;
    logic         stop;
`ifdef CLK_SCHED_PAUSE_EN
    logic         pause;
`endif
    logic         div_clk;
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] periods;

    int checks = 0;
    int errors = 0;
    int ticks;

    clk_enable_scheduler #(.CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_count (cfg_count),
        .start     (start),
        .stop      (stop),
`ifdef CLK_SCHED_PAUSE_EN
        .pause     (pause),
`endif
        .div_clk   (div_clk),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .periods   (periods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        cfg_count = '0;
        start     = 1'b0;
        stop      = 1'b0;
`ifdef CLK_SCHED_PAUSE_EN
        pause     = 1'b0;
`endif
        #2;
        check("rst_div_clk", div_clk, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_periods", periods, 0);
        step(2);
        rst = 1'b0;
        step(1);
        check("post_rst_cfg_ready", cfg_ready, 1);

        // start before any config is ignored
        start = 1'b1; step(1); start = 1'b0;
        check("start_unloaded_busy", busy, 0);

        // config and start together: config latched, start ignored
        cfg_valid = 1'b1; cfg_half = 4'd3; cfg_count = 4'd4; start = 1'b1;
        step(1);
        cfg_valid = 1'b0; start = 1'b0;
        check("cfg_start_same_cycle_busy", busy, 0);

        // counted burst: half=3, count=4
        start = 1'b1; step(1); start = 1'b0;
        check("burst_busy_e0", busy, 1);
        check("burst_div_e0", div_clk, 0);
        ticks = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 10) begin
                cfg_valid = 1'b1; cfg_half = 4'd7; cfg_count = 4'd1;
            end
            step(1);
            if (tick) ticks++;
            if (k == 12) cfg_valid = 1'b0;
            if (k == 2)  check("burst_div_e2", div_clk, 0);
            if (k == 3)  check("burst_div_e3", div_clk, 1);
            if (k == 3)  check("burst_tick_e3", tick, 1);
            if (k == 4)  check("burst_tick_e4", tick, 0);
            if (k == 6)  check("burst_div_e6", div_clk, 0);
            if (k == 6)  check("burst_periods_e6", periods, 1);
            if (k == 10) check("busy_cfg_ready", cfg_ready, 0);
            if (k == 23) check("burst_done_e23", done, 0);
            if (k == 24) check("burst_done_e24", done, 1);
            if (k == 24) check("burst_periods_e24", periods, 4);
            if (k == 24) check("burst_busy_e24", busy, 0);
            if (k == 24) check("burst_div_e24", div_clk, 0);
            if (k == 25) check("burst_done_e25", done, 0);
            if (k == 25) check("burst_periods_e25", periods, 4);
        end
        check("burst_ticks", ticks, 4);

        // rerun with retained config (busy-time cfg must not have loaded half=7)
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        check("rerun_rise_e3", div_clk, 1);
        step(4);
        check("rerun_periods_e7", periods, 1);
        stop = 1'b1; step(1); stop = 1'b0;
        check("stop_low_busy", busy, 0);
        check("stop_low_div", div_clk, 0);
        check("stop_low_done", done, 0);

        // stop during high phase: half=5, free-run
        cfg_valid = 1'b1; cfg_half = 4'd5; cfg_count = 4'd0; step(1); cfg_valid = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        check("h5_div_e5", div_clk, 1);
        check("h5_tick_e5", tick, 1);
        step(2);
        stop = 1'b1; step(1); stop = 1'b0;
        check("stopping_busy_e8", busy, 1);
        check("stopping_div_e8", div_clk, 1);
        step(1);
        check("stopping_div_e9", div_clk, 1);
        step(1);
        check("stopped_div_e10", div_clk, 0);
        check("stopped_busy_e10", busy, 0);
        check("stopped_done_e10", done, 0);
        check("stopped_periods_e10", periods, 1);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy, 0);

        // free-run with half=0 (treated as 1), periods wrap
        cfg_valid = 1'b1; cfg_half = 4'd0; cfg_count = 4'd0; step(1); cfg_valid = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        ticks = 0;
        for (int k = 1; k <= 32; k++) begin
            step(1);
            if (tick) ticks++;
            if (k == 1)  check("h0_div_e1", div_clk, 1);
            if (k == 1)  check("h0_tick_e1", tick, 1);
            if (k == 2)  check("h0_div_e2", div_clk, 0);
            if (k == 2)  check("h0_tick_e2", tick, 0);
            if (k == 2)  check("h0_periods_e2", periods, 1);
            if (k == 30) check("h0_periods_e30", periods, 15);
            if (k == 32) check("h0_periods_wrap", periods, 0);
            if (k == 32) check("h0_busy_e32", busy, 1);
        end
        check("h0_ticks", ticks, 16);
        stop = 1'b1; step(1); stop = 1'b0;
        check("h0_stop_busy", busy, 0);

        // asynchronous reset mid-run with div_clk high
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        check("pre_rst_div", div_clk, 1);
        check("pre_rst_periods", periods, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_div", div_clk, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_periods", periods, 0);
        check("mid_rst_done", done, 0);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_mid_rst_cfg_ready", cfg_ready, 1);
        start = 1'b1; step(1); start = 1'b0;
        check("post_rst_unloaded_busy", busy, 0);

`ifdef CLK_SCHED_PAUSE_EN
        // pause held 10 cycles mid-high-phase: half=4 high phase becomes 14 cycles
        cfg_valid = 1'b1; cfg_half = 4'd4; cfg_count = 4'd0; step(1); cfg_valid = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        check("pause_div_e5", div_clk, 1);
        pause = 1'b1;
        step(10);
        check("pause_div_e15", div_clk, 1);
        check("pause_periods_e15", periods, 0);
        check("pause_tick_e15", tick, 0);
        pause = 1'b0;
        step(2);
        check("pause_div_e17", div_clk, 1);
        step(1);
        check("pause_div_e18", div_clk, 0);
        check("pause_periods_e18", periods, 1);
        stop = 1'b1; step(1); stop = 1'b0;
        check("pause_stop_busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
